// File: rtl/data_bus.sv
// Hack-style data bus: RAM, write-buffered screen FIFO, synchronized keyboard,
// down-counting timer with sticky expiry, and a status word.
module data_bus #(
    parameter int RAM_WORDS  = 16384,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    output logic        stall,
    input  logic [15:0] kbd_code,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        scr_valid,
    input  logic        scr_ready
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        REG_NONE, REG_RAM, REG_SCR, REG_KBD, REG_TMR, REG_STAT
    } region_t;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } entry_t;

    region_t region;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        region = REG_NONE;
        if (32'(addressM) < RAM_WORDS && addressM < 16'h4000)
            region = REG_RAM;
        else if (addressM >= 16'h4000 && addressM <= 16'h5FFF)
            region = REG_SCR;
        else if (addressM == 16'h6000)
            region = REG_KBD;
        else if (addressM == 16'h6001)
            region = REG_TMR;
        else if (addressM == 16'h6002)
            region = REG_STAT;
    end

    logic [15:0] ram [RAM_WORDS];

    // NOTE: the RAM array has no reset; its contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (writeM && region == REG_RAM)
            ram[addressM[RAM_AW-1:0]] <= outM;
    end

    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign scr_valid  = !fifo_empty;
    assign pop        = scr_valid && scr_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = writeM && region == REG_SCR && (!fifo_full || pop);
    assign stall      = writeM && region == REG_SCR && fifo_full && !pop;
    assign scr_addr   = fifo_mem[rd_ptr].addr;
    assign scr_data   = fifo_mem[rd_ptr].data;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{addr: addressM[12:0], data: outM};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    logic [15:0] kbd_sync1;
    logic [15:0] kbd_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_sync1 <= '0;
            kbd_sync2 <= '0;
        end else begin
            kbd_sync1 <= kbd_code;
            kbd_sync2 <= kbd_sync1;
        end
    end

    logic [15:0] timer;
    logic        expired;

    // A load takes priority over the 1 -> 0 step, so a concurrent load never flags expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            expired <= 1'b0;
        end else begin
            if (writeM && region == REG_TMR) begin
                timer <= outM;
            end else if (timer != 16'd0) begin
                timer <= timer - 16'd1;
                if (timer == 16'd1)
                    expired <= 1'b1;
            end
            if (writeM && region == REG_STAT)
                expired <= 1'b0;
        end
    end

    logic [15:0] status;
    assign status = {13'd0, expired, fifo_full, fifo_empty};

    always_comb begin
        inM = 16'h0000;
        case (region)
            REG_RAM:  inM = ram[addressM[RAM_AW-1:0]];
            REG_KBD:  inM = kbd_sync2;
            REG_TMR:  inM = timer;
            REG_STAT: inM = status;
            default:  inM = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_data_bus.sv
// Directed bench for data_bus: inline checks for reads, a queue-based
// scoreboard with an independent monitor for screen FIFO pops.
module tb_data_bus;

    logic        clk;
    logic        reset;
    logic [15:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        stall;
    logic [15:0] kbd_code;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_valid;
    logic        scr_ready;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [12:0] a;
        logic [15:0] d;
    } entry_t;

    entry_t sb[$];

    data_bus #(.RAM_WORDS(1024), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .addressM  (addressM),
        .outM      (outM),
        .writeM    (writeM),
        .inM       (inM),
        .stall     (stall),
        .kbd_code  (kbd_code),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .scr_valid (scr_valid),
        .scr_ready (scr_ready)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set(input logic [15:0] a, input logic [15:0] d, input logic w);
        addressM = a;
        outM     = d;
        writeM   = w;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (reset && scr_valid && scr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scr_unexpected_pop: got addr 0x%0h data 0x%0h with nothing expected",
                         scr_addr, scr_data);
            end else begin
                entry_t e;
                e = sb.pop_front();
                check("scr_addr", 32'(scr_addr), 32'(e.a));
                check("scr_data", 32'(scr_data), 32'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        addressM  = '0;
        outM      = '0;
        writeM    = 1'b0;
        kbd_code  = 16'h5555;
        scr_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        set(16'h6002, 0, 0); check("rst_status", inM, 16'h0001);
        check("rst_scr_valid", scr_valid, 0);
        check("rst_stall", stall, 0);
        set(16'h6000, 0, 0); check("rst_kbd", inM, 16'h0000);
        set(16'h6001, 0, 0); check("rst_timer", inM, 16'h0000);
        kbd_code = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        tick();

        // RAM write/read, RAM_WORDS boundary, unmapped space
        set(16'h0010, 16'h1234, 1); tick();
        set(16'h0010, 0, 0); check("ram_0010", inM, 16'h1234);
        set(16'h7000, 0, 0); check("unmapped_7000", inM, 16'h0000);
        set(16'h0000, 16'h1111, 1); tick();
        set(16'h03FF, 16'hCAFE, 1); tick();
        set(16'h0400, 16'hDEAD, 1); tick();
        set(16'h7000, 16'hFFFF, 1); tick();
        set(16'h03FF, 0, 0); check("ram_top_word", inM, 16'hCAFE);
        set(16'h0400, 0, 0); check("ram_beyond_words", inM, 16'h0000);
        set(16'h0000, 0, 0); check("ram_no_alias", inM, 16'h1111);
        tick();
        set(16'h7000, 0, 0); check("unmapped_after_write", inM, 16'h0000);
        set(16'h6003, 0, 0); check("unmapped_6003", inM, 16'h0000);

        // Keyboard synchronizer latency
        tick();
        kbd_code = 16'h0041;
        set(16'h6000, 0, 0); check("kbd_0_edges", inM, 16'h0000);
        tick(); check("kbd_1_edge", inM, 16'h0000);
        tick(); check("kbd_2_edges", inM, 16'h0041);
        set(16'h6000, 16'hBEEF, 1); tick();
        set(16'h6000, 0, 0); check("kbd_write_ignored", inM, 16'h0041);

        // Timer countdown and sticky expiry
        set(16'h6001, 16'd3, 1); tick();
        set(16'h6001, 0, 0); check("timer_3", inM, 16'd3);
        tick(); check("timer_2", inM, 16'd2);
        tick(); check("timer_1", inM, 16'd1);
        tick(); check("timer_0", inM, 16'd0);
        set(16'h6002, 0, 0); check("status_expired", inM, 16'h0005);
        tick();
        set(16'h6001, 0, 0); check("timer_hold_0", inM, 16'd0);
        set(16'h6002, 0, 1); tick();
        set(16'h6002, 0, 0); check("status_expired_clear", inM, 16'h0001);

        // Load concurrent with 1 -> 0 wins; load of 0 never flags
        set(16'h6001, 16'd1, 1); tick();
        set(16'h6001, 16'd7, 1); tick();
        set(16'h6002, 0, 0); check("load_beats_expire_status", inM, 16'h0001);
        set(16'h6001, 0, 0); check("load_beats_expire_timer", inM, 16'd7);
        set(16'h6001, 0, 1); tick();
        set(16'h6001, 0, 0); check("load_zero_timer", inM, 16'd0);
        set(16'h6002, 0, 0); check("load_zero_no_flag", inM, 16'h0001);

        // Screen FIFO fill, stall, pop-while-full, ordered drain
        scr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set(16'h4000 + 16'(i), 16'hA000 + 16'(i), 1);
            check("fill_no_stall", stall, 0);
            sb.push_back('{a: 13'(i), d: 16'hA000 + 16'(i)});
            tick();
        end
        set(16'h4004, 16'hA004, 1); check("full_stall", stall, 1);
        tick();
        set(16'h6002, 0, 0); check("status_full", inM, 16'h0002);
        set(16'h4004, 16'hA004, 1);
        scr_ready = 1'b1;
        #1;
        check("full_pop_no_stall", stall, 0);
        sb.push_back('{a: 13'h0004, d: 16'hA004});
        tick();
        scr_ready = 1'b0;
        set(16'h6002, 0, 0); check("status_still_full", inM, 16'h0002);
        scr_ready = 1'b1;
        repeat (4) tick();
        check("status_drained", inM, 16'h0001);

        // Top of screen range, and KBD write does not enter the FIFO
        set(16'h5FFF, 16'h0F0F, 1);
        sb.push_back('{a: 13'h1FFF, d: 16'h0F0F});
        tick();
        set(16'h6000, 16'h1234, 1); tick();
        set(16'h6002, 0, 0); check("status_after_boundary", inM, 16'h0001);

        // Reset mid-cycle discards queued entries, RAM preserved
        scr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set(16'h4100 + 16'(i), 16'hB000 + 16'(i), 1);
            sb.push_back('{a: 13'h0100 + 13'(i), d: 16'hB000 + 16'(i)});
            tick();
        end
        set(16'h6002, 0, 0); check("status_partial", inM, 16'h0000);
        check("valid_before_reset", scr_valid, 1);
        reset = 1'b0;
        sb.delete();
        #1;
        check("reset_valid_drop", scr_valid, 0);
        check("reset_status", inM, 16'h0001);
        set(16'h0010, 0, 0); check("reset_ram_kept", inM, 16'h1234);
        set(16'h6000, 0, 0); check("reset_kbd_clear", inM, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        tick();
        set(16'h6002, 0, 0); check("post_reset_status", inM, 16'h0001);
        check("post_reset_valid", scr_valid, 0);

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
